// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the execute stage and mem_access_unit.
// The execute stage drives the master side; the load/store unit is the slave.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end for a word-addressed
// data memory. Sub-word stores are done as read-modify-write, sub-word loads
// are lane-extracted and sign/zero-extended. One request in flight at a time.
// Optional feature macro: MEMACC_MISALIGN_TRAP_EN (defined = misaligned
// requests return an error; undefined = low address bits are ignored and the
// access proceeds at the aligned address). The out-of-range check is always on.
module mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic [31:0]        mem_addr,
  output logic               mem_writeEn,
  output logic [31:0]        mem_dataIn,
  input  logic [31:0]        mem_dataOut
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW,
    WRITE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic        err_q, err_d;

  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_is_word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;
  logic [31:0] merge_value;

  // Classify the incoming request: size 11 counts as word, range and alignment checks.
  always_comb begin
    req_is_word      = bus.req_size[1];
    req_out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W);
    req_misaligned   = 1'b0;
`ifdef MEMACC_MISALIGN_TRAP_EN
    if (bus.req_size == 2'b01) begin
      req_misaligned = bus.req_addr[0];
    end else if (req_is_word) begin
      req_misaligned = (bus.req_addr[1:0] != 2'b00);
    end
`else
    req_misaligned   = 1'b0;
`endif
  end

  // Lane extraction for loads and lane replacement for read-modify-write stores.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_dataOut[7:0];
      2'd1:    byte_lane = mem_dataOut[15:8];
      2'd2:    byte_lane = mem_dataOut[23:16];
      default: byte_lane = mem_dataOut[31:24];
    endcase
    half_lane = addr_q[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];

    if (size_q == 2'b00) begin
      load_value = {{24{signed_q & byte_lane[7]}}, byte_lane};
    end else if (size_q == 2'b01) begin
      load_value = {{16{signed_q & half_lane[15]}}, half_lane};
    end else begin
      load_value = mem_dataOut;
    end

    merge_value = mem_dataOut;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_value[7:0]   = wdata_q[7:0];
        2'd1:    merge_value[15:8]  = wdata_q[7:0];
        2'd2:    merge_value[23:16] = wdata_q[7:0];
        default: merge_value[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_value[31:16] = wdata_q[15:0];
    end else begin
      merge_value[15:0]  = wdata_q[15:0];
    end
  end

  // State register plus request/merge/result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: errors skip memory, loads read once, sub-word stores read then write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_misaligned || req_out_of_range) begin
            state_d = DONE;
          end else if (!bus.req_write) begin
            state_d = LOAD;
          end else if (req_is_word) begin
            state_d = WRITE;
          end else begin
            state_d = RMW;
          end
        end
      end
      LOAD:    state_d = DONE;
      RMW:     state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates: latch the request on accept, capture read data later.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          size_d   = req_is_word ? 2'b10 : bus.req_size;
          signed_d = bus.req_signed;
          write_d  = bus.req_write;
          err_d    = req_misaligned | req_out_of_range;
          rdata_d  = 32'h0;
        end
      end
      LOAD:    rdata_d = load_value;
      RMW:     merge_d = merge_value;
      default: ;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.resp_err   = (state_q == DONE) & err_q;
    bus.resp_rdata = ((state_q == DONE) && !write_q) ? rdata_q : 32'h0;
    mem_addr       = (state_q == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    mem_writeEn    = (state_q == WRITE);
    mem_dataIn     = 32'h0;
    if (state_q == WRITE) begin
      mem_dataIn = size_q[1] ? wdata_q : merge_q;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed sequence followed by random
// requests, checked by a scoreboard fed from a byte-level memory model.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_cycle;
    int          latency;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_writeEn;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;
  logic        preload;

  logic [31:0] mem_array [MEM_WORDS];
  logic [31:0] ref_mem   [MEM_WORDS];

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  mon_w;

  int cycle        = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .mem_addr    (mem_addr),
    .mem_writeEn (mem_writeEn),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Data memory seen by the DUT: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_array[i] <= ref_mem[i];
    end else if (mem_writeEn && mem_addr < 32'(MEM_WORDS)) begin
      mem_array[mem_addr[7:0]] <= mem_dataIn;
    end
  end

  assign mem_dataOut = (mem_addr < 32'(MEM_WORDS)) ? mem_array[mem_addr[7:0]] : 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference behaviour computed from byte lanes with plain arithmetic.
  task automatic model_request(input bit w, input logic [1:0] sz, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output exp_t e, output bit has_wr, output wr_t wr);
    int          idx;
    int          nbytes;
    int          off;
    logic [31:0] mask;
    logic [31:0] word;
    logic [31:0] val;
    bit          err;
    idx    = int'(addr >> 2);
    err    = ((addr >> 2) >= 32'(MEM_WORDS));
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef MEMACC_MISALIGN_TRAP_EN
    if ((addr % nbytes) != 0) err = 1'b1;
`endif
    off    = (int'(addr % 4) / nbytes) * nbytes;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    e.rdata        = 32'h0;
    e.err          = err;
    e.accept_cycle = 0;
    e.latency      = err ? 1 : (!w ? 2 : (nbytes == 4 ? 2 : 3));
    has_wr         = 1'b0;
    wr.addr        = 32'h0;
    wr.data        = 32'h0;
    if (!err) begin
      word = ref_mem[idx];
      if (!w) begin
        val = (word >> (8 * off)) & mask;
        if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        e.rdata = val;
      end else begin
        word = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        ref_mem[idx] = word;
        has_wr  = 1'b1;
        wr.addr = 32'(idx);
        wr.data = word;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.req_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ready_timeout: req_ready stayed 0 for %0d cycles", n);
    end else begin
      checkOutput("idle_mem_addr", mem_addr, 32'h0);
    end
  endtask

  task automatic scramble_req();
    bus_if.req_write  = 1'($urandom);
    bus_if.req_size   = 2'($urandom);
    bus_if.req_signed = 1'($urandom);
    bus_if.req_addr   = $urandom;
    bus_if.req_wdata  = $urandom;
  endtask

  task automatic applyStimulus(input bit w, input logic [1:0] sz, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   has_wr;
    wr_t  wr;
    wait_ready();
    bus_if.req_write  = w;
    bus_if.req_size   = sz;
    bus_if.req_signed = sgn;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    model_request(w, sz, sgn, addr, wdata, e, has_wr, wr);
    e.accept_cycle = cycle;
    exp_q.push_back(e);
    if (has_wr) wr_q.push_back(wr);
    bus_if.req_valid = 1'b0;
    scramble_req();
  endtask

  // Monitor: compare every response and every memory write against the scoreboard.
  always @(negedge clk) begin
    if (reset && bus_if.resp_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_resp: rdata 0x%08h err %0b with nothing outstanding",
                 bus_if.resp_rdata, bus_if.resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("resp_rdata", bus_if.resp_rdata, mon_e.rdata);
        checkOutput("resp_err", {31'b0, bus_if.resp_err}, {31'b0, mon_e.err});
        checkOutput("resp_latency", 32'(cycle - mon_e.accept_cycle + 1), 32'(mon_e.latency));
      end
    end
    if (reset && mem_writeEn) begin
      if (wr_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: addr 0x%08h data 0x%08h", mem_addr, mem_dataIn);
      end else begin
        mon_w = wr_q.pop_front();
        checkOutput("write_addr", mem_addr, mon_w.addr);
        checkOutput("write_data", mem_dataIn, mon_w.data);
      end
    end
  end

  initial begin
    int n;
    int mism;
    bit          w;
    logic [1:0]  sz;
    bit          sgn;
    logic [31:0] addr;

    reset             = 1'b0;
    preload           = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_size   = 2'b00;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;

    #1;
    checkOutput("rst_req_ready", {31'b0, bus_if.req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'b0, bus_if.resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'b0, bus_if.resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    checkOutput("rst_mem_writeEn", {31'b0, mem_writeEn}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_dataIn", mem_dataIn, 32'h0);

    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    reset   = 1'b1;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'(4 * MEM_WORDS), 32'hCAFE_F00D);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

    // Abort a sub-word store in its read-modify-write phase with reset.
    wait_ready();
    bus_if.req_write  = 1'b1;
    bus_if.req_size   = 2'b00;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = 32'h10;
    bus_if.req_wdata  = 32'h55;
    bus_if.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_writeEn", {31'b0, mem_writeEn}, 32'h0);
    checkOutput("abort_ready", {31'b0, bus_if.req_ready}, 32'h1);
    checkOutput("abort_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_word4", mem_array[4], 32'hDEAD_AAEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    for (int k = 0; k < 300; k++) begin
      w   = 1'($urandom);
      sz  = 2'($urandom);
      sgn = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(4 * MEM_WORDS - 8, 4 * MEM_WORDS + 7));
        2, 3, 4: addr = 32'($urandom_range(0, 63));
        default: addr = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      endcase
      applyStimulus(w, sz, sgn, addr, $urandom);
    end

    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_resp", 32'(exp_q.size()), 32'h0);
    checkOutput("drain_write", 32'(wr_q.size()), 32'h0);

    mism = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (mem_array[i] !== ref_mem[i]) mism++;
    end
    checkOutput("final_mem_words_differing", 32'(mism), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end placed directly upstream of the word-addressed data memory. It accepts byte-addressed load/store requests of byte, halfword or word size and converts them into word accesses. Sub-word stores use a read-modify-write sequence. Sub-word loads are lane-extracted and sign- or zero-extended. Results return to the execute stage over a one-request-at-a-time valid/ready handshake.

## Interface
- MEM_WORDS, 256: number of 32-bit words in the data memory; word index ≥ MEM_WORDS is out of range.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_signed  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address, little-endian lanes.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse; request complete.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; misaligned or out-of-range access.
- mem_addr  output  32  word index = {2'b00, latched addr[31:2]}.
- mem_writeEn  output  1  memory write strobe.
- mem_dataIn  output  32  full word written to memory.
- mem_dataOut  input  32  combinational read data from memory at mem_addr.

## Operation
- States: IDLE, LOAD, RMW, WRITE, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, size, signed, write and wdata, then run the checks:
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) or addr[31:2] ≥ MEM_WORDS → DONE with err=1; no memory access.
  - load → LOAD.
  - word store → WRITE.
  - byte/half store → RMW.
- LOAD: sample mem_dataOut. Extract lane addr[1:0] (byte) or addr[1] (half), extend per signed, register into resp_rdata. → DONE.
- RMW: sample mem_dataOut into the merge register. Replace only the addressed byte/half with wdata[7:0]/[15:0]; keep all other bits. → WRITE.
- WRITE: mem_writeEn=1 for exactly this cycle. mem_dataIn = merge register (sub-word) or latched wdata (word). → DONE.
- DONE: resp_valid=1 and resp_err as latched. → IDLE unconditionally; there is no response backpressure.
- mem_writeEn is never high outside WRITE. mem_addr holds the latched index in every non-IDLE state and is 0 in IDLE.
- Error responses and store responses carry resp_rdata=0.

## Timing
- Request accepted on the rising edge where req_valid & req_ready.
- resp_valid rises this many edges after acceptance:
  - load: 2.
  - word store: 2.
  - byte/half store: 3.
  - error: 1.
- Back-to-back: the next request can be accepted in the cycle after DONE. Minimum spacing is 3 cycles for a word access.
- req_* inputs are ignored outside the IDLE accept edge; changing them mid-operation has no effect.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_writeEn=0, mem_addr=0, mem_dataIn=0, merge register 0.
- Reset asserted mid-operation forces IDLE immediately (asynchronously):
  - mem_writeEn drops in the same cycle, so an in-flight RMW write is aborted and memory keeps its old word.
  - No response is issued for the aborted request.

## Configuration
- MEMACC_MISALIGN_TRAP_EN defined: misaligned requests produce resp_err=1 after 1 cycle with no memory access.
- Not defined: misalignment is never an error.
  - addr[0] is ignored for halfword requests; addr[1:0] are ignored for word requests.
  - The request proceeds at the aligned address.
- The out-of-range check is always active.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10: mem_writeEn pulses once with mem_addr=4. The load returns 0xDEADBEEF, err=0, resp_valid 2 edges after acceptance.
- After that, byte store 0xAA @0x11: RMW writes 0xDEADAAEF to word 4, resp_valid 3 edges after acceptance. A following word load returns 0xDEADAAEF.
- Halfword load @0x12:
  - signed=1 → 0xFFFFDEAD.
  - signed=0 → 0x0000DEAD.
- Word load @0x13:
  - with MEMACC_MISALIGN_TRAP_EN: err=1 after 1 edge, rdata=0, no memory access.
  - without it: returns 0xDEADAAEF.
- Word store @ byte address 4*MEM_WORDS: err=1, mem_writeEn never asserts, and the memory contents are unchanged.
- Byte store 0x55 @0x10 with reset asserted during RMW: mem_writeEn stays 0, no resp_valid, state returns to IDLE. Word 4 stays 0xDEADAAEF.
